// File: rtl/mfcc_post_stage_seq.sv
// rtl/mfcc_post_stage_seq.sv - Post-DCT MFCC stage sequencer with shared feature-memory port mux
//
// Sequences the cepstrum write-back, delta and 2nd-order delta engines. Each engine
// gets a level run enable while its stage is active. The single shared feature-memory
// write port goes to whichever engine owns the current stage. A per-stage watchdog
// traps engines that never report done.
//
// Ports:
//   clk_i, rst_n_i                 clock (rising edge), asynchronous active-low reset
//   start_i, abort_i, clear_i      sequence start pulse, synchronous abort, leave ERR
//   frame_num_i, cep_num_i         configuration, sampled on an accepted start
//   *_done_i                       one-cycle done pulses from the three engines
//   *_addr_i, *_we_i, *_wdata_i    per-engine memory write requests
//   *_state_en_o                   engine run enables (level)
//   frame_num_q_o, cep_num_q_o     captured configuration
//   mem_addr_o, mem_we_o, mem_wdata_o  shared memory port
//   busy_o, done_o, delta_skipped_o, err_o, err_code_o  status

module mfcc_post_stage_seq #(
    parameter int ADDR_WIDTH_14 = 14,
    parameter int DATA_WIDTH    = 32,
    parameter int MIN_FRAMES    = 5,
    parameter int MAX_CEP       = 13,
    parameter int TIMEOUT       = 4095
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     clear_i,
    input  logic [6:0]               frame_num_i,
    input  logic [6:0]               cep_num_i,
    input  logic                     cep_done_i,
    input  logic                     delta_done_i,
    input  logic                     delta_2nd_done_i,
    input  logic [ADDR_WIDTH_14-1:0] cep_addr_i,
    input  logic [ADDR_WIDTH_14-1:0] delta_addr_i,
    input  logic [ADDR_WIDTH_14-1:0] delta_2nd_addr_i,
    input  logic                     cep_we_i,
    input  logic                     delta_we_i,
    input  logic                     delta_2nd_we_i,
    input  logic [DATA_WIDTH-1:0]    cep_wdata_i,
    input  logic [DATA_WIDTH-1:0]    delta_wdata_i,
    input  logic [DATA_WIDTH-1:0]    delta_2nd_wdata_i,
    output logic                     cep_state_en_o,
    output logic                     delta_state_en_o,
    output logic                     delta_2nd_state_en_o,
    output logic [6:0]               frame_num_q_o,
    output logic [6:0]               cep_num_q_o,
    output logic [ADDR_WIDTH_14-1:0] mem_addr_o,
    output logic                     mem_we_o,
    output logic [DATA_WIDTH-1:0]    mem_wdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     delta_skipped_o,
    output logic                     err_o,
    output logic [1:0]               err_code_o
);

    localparam logic [6:0]  MIN_FRAMES_C = 7'(MIN_FRAMES);
    localparam logic [6:0]  MAX_CEP_C    = 7'(MAX_CEP);
    // The stage times out on the cycle the count would reach TIMEOUT.
    localparam logic [11:0] WDOG_LAST    = 12'(TIMEOUT - 1);

    localparam logic [1:0] ERR_CFG  = 2'b01;
    localparam logic [1:0] ERR_WDOG = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CEP    = 3'd1,
        S_DELTA  = 3'd2,
        S_DELTA2 = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  frame_num_q, frame_num_d;
    logic [6:0]  cep_num_q, cep_num_d;
    logic        skipped_q, skipped_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [11:0] wdog_q, wdog_d;

    logic        wdog_expired;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            frame_num_q <= '0;
            cep_num_q   <= '0;
            skipped_q   <= 1'b0;
            err_code_q  <= '0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            frame_num_q <= frame_num_d;
            cep_num_q   <= cep_num_d;
            skipped_q   <= skipped_d;
            err_code_q  <= err_code_d;
            wdog_q      <= wdog_d;
        end
    end

    // Watchdog defaults to 0; it only counts while a stage stays put, so every
    // stage entry starts from a clean count.
    always_comb begin
        state_d     = state_q;
        frame_num_d = frame_num_q;
        cep_num_d   = cep_num_q;
        skipped_d   = skipped_q;
        err_code_d  = err_code_q;
        wdog_d      = '0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    frame_num_d = frame_num_i;
                    cep_num_d   = cep_num_i;
                    skipped_d   = 1'b0;
                    if (cep_num_i == 7'd0 || cep_num_i > MAX_CEP_C) begin
                        state_d    = S_ERR;
                        err_code_d = ERR_CFG;
                    end else begin
                        state_d = S_CEP;
                    end
                end
            end
            S_CEP: begin
                // done beats an expiring watchdog in the same cycle
                if (cep_done_i) begin
                    if (frame_num_q >= MIN_FRAMES_C) begin
                        state_d = S_DELTA;
                    end else begin
                        state_d   = S_DONE;
                        skipped_d = 1'b1;
                    end
                end else if (wdog_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_WDOG;
                end else begin
                    wdog_d = wdog_q + 12'd1;
                end
            end
            S_DELTA: begin
                if (delta_done_i) begin
                    state_d = S_DELTA2;
                end else if (wdog_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_WDOG;
                end else begin
                    wdog_d = wdog_q + 12'd1;
                end
            end
            S_DELTA2: begin
                if (delta_2nd_done_i) begin
                    state_d = S_DONE;
                end else if (wdog_expired) begin
                    state_d    = S_ERR;
                    err_code_d = ERR_WDOG;
                end else begin
                    wdog_d = wdog_q + 12'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (clear_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    // Status and enables decode straight from the state register so an
    // asynchronous reset clears them without waiting for a clock.
    assign cep_state_en_o       = (state_q == S_CEP);
    assign delta_state_en_o     = (state_q == S_DELTA);
    assign delta_2nd_state_en_o = (state_q == S_DELTA2);
    assign busy_o               = cep_state_en_o | delta_state_en_o | delta_2nd_state_en_o;
    assign done_o               = (state_q == S_DONE);
    assign err_o                = (state_q == S_ERR);
    assign err_code_o           = err_o ? err_code_q : 2'b00;
    assign delta_skipped_o      = skipped_q;
    assign frame_num_q_o        = frame_num_q;
    assign cep_num_q_o          = cep_num_q;

    // Only the owning engine reaches the memory; every other state parks the port.
    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        unique case (state_q)
            S_CEP: begin
                mem_addr_o  = cep_addr_i;
                mem_we_o    = cep_we_i;
                mem_wdata_o = cep_wdata_i;
            end
            S_DELTA: begin
                mem_addr_o  = delta_addr_i;
                mem_we_o    = delta_we_i;
                mem_wdata_o = delta_wdata_i;
            end
            S_DELTA2: begin
                mem_addr_o  = delta_2nd_addr_i;
                mem_we_o    = delta_2nd_we_i;
                mem_wdata_o = delta_2nd_wdata_i;
            end
            default: begin
                mem_addr_o  = '0;
                mem_we_o    = 1'b0;
                mem_wdata_o = '0;
            end
        endcase
    end

endmodule
